// File: rtl/op_stream_decoder.sv
// op_stream_decoder: registered op classifier and audio stream tracker.
// Sits between the serial op deserialiser and the sample FIFO/DAC logic.
// Every response is registered and appears one clock after the op cycle.
module op_stream_decoder #(
  parameter int                  OP_WIDTH       = 16,
  parameter logic [OP_WIDTH-1:0] POWER_ON_OP    = OP_WIDTH'(16'hc5ef),
  parameter int                  CNT_WIDTH      = 16,
  parameter int                  TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OP_WIDTH-1:0]  op,
  input  logic                 op_valid,
  output logic                 sample_valid,
  output logic [OP_WIDTH-9:0]  sample_data,
  output logic                 audio_starts,
  output logic                 rate_44k,
  output logic                 stream_active,
  output logic                 stream_timeout,
  output logic                 orphan_sample,
  output logic                 all_1_packet,
  output logic                 power_on_packet_R1,
  output logic                 powered,
  output logic [CNT_WIDTH-1:0] sample_count
);

  localparam int PAY_W = OP_WIDTH - 8;
  localparam int TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_ALL1    = 3'd1,
    OP_PWR     = 3'd2,
    OP_START22 = 3'd3,
    OP_START44 = 3'd4,
    OP_SAMPLE  = 3'd5,
    OP_OTHER   = 3'd6
  } op_cls_t;

  // Sample counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_WIDTH'(1);
  endfunction

  // ---- stage p0: combinational classification of the incoming op ----
  logic [7:0]       opcode_p0;
  logic [PAY_W-1:0] payload_p0;
  op_cls_t          op_cls_p0;
  logic             to_fire_p0;

  assign opcode_p0  = op[OP_WIDTH-1 -: 8];
  assign payload_p0 = op[PAY_W-1:0];

  // Priority decode of a valid op; all-ones beats the power-on match.
  always_comb begin
    op_cls_p0 = OP_NONE;
    if (op_valid) begin
      if (opcode_p0 == 8'hff) begin
        op_cls_p0 = OP_ALL1;
      end else if (op == POWER_ON_OP) begin
        op_cls_p0 = OP_PWR;
      end else if (opcode_p0 == 8'h1f) begin
        op_cls_p0 = OP_START22;
      end else if (opcode_p0 == 8'h0f) begin
        op_cls_p0 = OP_START44;
      end else if (opcode_p0 == 8'hc7) begin
        op_cls_p0 = OP_SAMPLE;
      end else begin
        op_cls_p0 = OP_OTHER;
      end
    end
  end

  // ---- stage p1: registered FSM state and outputs ----
  state_t state_p1;
  state_t state_nxt;

  logic                 sample_valid_nxt;
  logic [PAY_W-1:0]     sample_data_nxt;
  logic                 audio_starts_nxt;
  logic                 rate_44k_nxt;
  logic                 stream_timeout_nxt;
  logic                 orphan_sample_nxt;
  logic                 all_1_packet_nxt;
  logic                 power_on_nxt;
  logic                 powered_nxt;
  logic [CNT_WIDTH-1:0] sample_count_nxt;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      logic [TO_W-1:0] to_cnt_p1;

      // The op-free cycle that finds the counter one short of the limit expires the stream.
      assign to_fire_p0 = (state_p1 == S_STREAM) && !op_valid &&
                          (to_cnt_p1 == TO_W'(TIMEOUT_CYCLES - 1));

      // Inactivity counter: runs only while streaming, any op restarts it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          to_cnt_p1 <= '0;
        end else if ((state_p1 != S_STREAM) || op_valid || to_fire_p0) begin
          to_cnt_p1 <= '0;
        end else begin
          to_cnt_p1 <= to_cnt_p1 + TO_W'(1);
        end
      end
    end else begin : g_no_timeout
      assign to_fire_p0 = 1'b0;
    end
  endgenerate

  // Next-state and next-output decision; pulses default low, held values default to current.
  always_comb begin
    state_nxt          = state_p1;
    sample_valid_nxt   = 1'b0;
    sample_data_nxt    = sample_data;
    audio_starts_nxt   = 1'b0;
    rate_44k_nxt       = rate_44k;
    stream_timeout_nxt = 1'b0;
    orphan_sample_nxt  = 1'b0;
    all_1_packet_nxt   = 1'b0;
    power_on_nxt       = 1'b0;
    powered_nxt        = powered;
    sample_count_nxt   = sample_count;

    case (op_cls_p0)
      OP_ALL1: begin
        state_nxt        = S_IDLE;
        all_1_packet_nxt = 1'b1;
        powered_nxt      = 1'b0;
        sample_count_nxt = '0;
        rate_44k_nxt     = 1'b0;
      end
      OP_PWR: begin
        power_on_nxt = 1'b1;
        powered_nxt  = 1'b1;
      end
      OP_START22, OP_START44: begin
        // A start inside a running stream restarts it with the same actions.
        state_nxt        = S_STREAM;
        audio_starts_nxt = 1'b1;
        rate_44k_nxt     = (op_cls_p0 == OP_START44);
        sample_count_nxt = '0;
      end
      OP_SAMPLE: begin
        if (state_p1 == S_STREAM) begin
          sample_valid_nxt = 1'b1;
          sample_data_nxt  = payload_p0;
          sample_count_nxt = sat_inc(sample_count);
        end else begin
          orphan_sample_nxt = 1'b1;
        end
      end
      default: begin
        // Timeout can only fire on an op-free cycle; rate and count stay readable.
        if (to_fire_p0) begin
          state_nxt          = S_IDLE;
          stream_timeout_nxt = 1'b1;
        end
      end
    endcase
  end

  // State and output registers; reset returns everything to zero with no pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1           <= S_IDLE;
      sample_valid       <= 1'b0;
      sample_data        <= '0;
      audio_starts       <= 1'b0;
      rate_44k           <= 1'b0;
      stream_timeout     <= 1'b0;
      orphan_sample      <= 1'b0;
      all_1_packet       <= 1'b0;
      power_on_packet_R1 <= 1'b0;
      powered            <= 1'b0;
      sample_count       <= '0;
    end else begin
      state_p1           <= state_nxt;
      sample_valid       <= sample_valid_nxt;
      sample_data        <= sample_data_nxt;
      audio_starts       <= audio_starts_nxt;
      rate_44k           <= rate_44k_nxt;
      stream_timeout     <= stream_timeout_nxt;
      orphan_sample      <= orphan_sample_nxt;
      all_1_packet       <= all_1_packet_nxt;
      power_on_packet_R1 <= power_on_nxt;
      powered            <= powered_nxt;
      sample_count       <= sample_count_nxt;
    end
  end

  assign stream_active = (state_p1 == S_STREAM);

endmodule

// File: doc/op_stream_decoder.md
Name: op_stream_decoder

Overview:
Registered, parametrised successor to the combinational op decoder in the sound-box datapath. It classifies each incoming op word and tracks audio stream state: the 22 kHz/44 kHz rate, whether a stream is active, sample delivery, sample counting and inactivity timeout. It sits between the serial op deserialiser and the audio sample FIFO/DAC logic. All outputs are registered.

Parameters:
OP_WIDTH, 16, op word width; must be >= 16; the opcode field is always op[OP_WIDTH-1 -: 8].
POWER_ON_OP, 16'hc5ef zero-extended to OP_WIDTH, exact full-word match for the power-on R1 packet.
CNT_WIDTH, 16, width of the sample counter.
TIMEOUT_CYCLES, 4096, number of consecutive op-free cycles in STREAM before timeout; 0 disables timeout.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  OP_WIDTH  op word, qualified by op_valid
op_valid  in  1  op strobe; one op per cycle when high
sample_valid  out  1  one-cycle pulse: sample accepted
sample_data  out  OP_WIDTH-8  payload op[OP_WIDTH-9:0], held until next sample
audio_starts  out  1  one-cycle pulse on a start op (22k or 44k)
rate_44k  out  1  latched rate: 1 = 44 kHz, 0 = 22 kHz
stream_active  out  1  high while FSM in STREAM
stream_timeout  out  1  one-cycle pulse on timeout exit
orphan_sample  out  1  one-cycle pulse: sample op received in IDLE (dropped)
all_1_packet  out  1  one-cycle pulse on an 0xff opcode
power_on_packet_R1  out  1  one-cycle pulse on an exact POWER_ON_OP match
powered  out  1  sticky; set by power-on, cleared by all-1 packet
sample_count  out  CNT_WIDTH  samples accepted in current stream, saturating

Behaviour:
- Reset (rst_n low, async): all outputs 0; FSM = IDLE; timeout counter 0.
- Latency: every response appears one clk after the op_valid cycle. Pulses last exactly one cycle.
- Decode, only when op_valid = 1, priority highest first:
  1. opcode 0xff -> ALL1.
  2. op == POWER_ON_OP -> PWR.
  3. opcode 0x1f -> START22.
  4. opcode 0x0f -> START44.
  5. opcode 0xc7 -> SAMPLE.
  6. anything else -> ignored; in STREAM it still restarts the timeout counter.
- FSM states: IDLE, STREAM.
- ALL1, any state:
  - Go to IDLE; all_1_packet pulse.
  - Clear powered, sample_count and rate_44k.
- PWR: power_on_packet_R1 pulse; powered <= 1; no state change.
- START22/START44, any state:
  - Go to STREAM; audio_starts pulse.
  - rate_44k <= (START44); sample_count <= 0.
  - A start while already in STREAM is a restart with the same actions.
- SAMPLE in STREAM:
  - sample_valid pulse; sample_data <= payload.
  - sample_count increments and saturates at all-ones; no wrap.
- SAMPLE in IDLE: orphan_sample pulse; sample_data and sample_count unchanged.
- Timeout (TIMEOUT_CYCLES > 0):
  - Counter runs only in STREAM. Any op_valid cycle clears it; each op-free cycle increments it.
  - When an op-free cycle finds the counter at TIMEOUT_CYCLES-1: go to IDLE, stream_timeout pulse, counter cleared.
  - rate_44k and sample_count are kept for software readback.
  - An op arriving in the cycle timeout would fire takes precedence; no timeout that cycle.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- TIMEOUT_CYCLES = 0: counter absent; stream_timeout tied 0.
- Reset asserted mid-stream: immediate return to reset values; no pulses generated.

Test Plan:
- Reset, then op 16'h0f00 -> next cycle audio_starts=1, rate_44k=1, stream_active=1. Then 3x 16'hc712/16'hc734/16'hc756 -> three sample_valid pulses, sample_data 0x12/0x34/0x56, sample_count=3.
- In IDLE, op 16'hc7aa -> orphan_sample=1, sample_valid=0, sample_count=0. Op 16'hc5ef -> power_on_packet_R1=1, powered=1. Op 16'hc5ee -> no response.
- In STREAM at 44k, op 16'h1f00 -> audio_starts=1, rate_44k=0, sample_count=0, still active. Then op 16'hffff -> all_1_packet=1, stream_active=0, powered=0, rate_44k=0.
- TIMEOUT_CYCLES=8, after start send no ops -> stream_timeout pulses exactly 8 cycles after the start op's response cycle, then stream_active=0. Repeat with op 16'h0000 arriving on cycle 8 -> no timeout, counter restarts.
- CNT_WIDTH=2, send 5 samples -> sample_count = 1, 2, 3, 3, 3; sample_valid pulses all 5 times.
- Assert rst_n low for 1 cycle mid-stream with op_valid high -> all outputs 0 asynchronously, no pulse after release.
